// File: rtl/cond_logic.sv
// Conditional-execution control stage: NZCV flag register, decode-cycle latch of
// the condition result, gated write enables and executed/skipped counters.

module condcheck (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic neg, zero, carry, overflow, ge;

    assign {neg, zero, carry, overflow} = Flags;
    assign ge = (neg == overflow);

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = zero;
            4'b0001: CondEx = ~zero;
            4'b0010: CondEx = carry;
            4'b0011: CondEx = ~carry;
            4'b0100: CondEx = neg;
            4'b0101: CondEx = ~neg;
            4'b0110: CondEx = overflow;
            4'b0111: CondEx = ~overflow;
            4'b1000: CondEx = ~zero & carry;
            4'b1001: CondEx = zero | ~carry;
            4'b1010: CondEx = ge;
            4'b1011: CondEx = ~ge;
            4'b1100: CondEx = ~zero & ge;
            4'b1101: CondEx = zero | ~ge;
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

module cond_logic #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             CondLatch,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             CntClr,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic             CondExLatched,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    logic condex;

    // Evaluated on the registered flags, so a same-cycle flag write is not seen.
    condcheck u_condcheck (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (condex)
    );

    // Flag halves are qualified by the result of the instruction already in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags         <= 4'b0000;
            CondExLatched <= 1'b0;
        end else begin
            if (FlagW[1] && CondExLatched)
                Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0] && CondExLatched)
                Flags[1:0] <= ALUFlags[1:0];
            if (CondLatch)
                CondExLatched <= condex;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ExecCount <= '0;
            SkipCount <= '0;
        end else if (CntClr) begin
            ExecCount <= '0;
            SkipCount <= '0;
        end else if (CondLatch) begin
            if (condex)
                ExecCount <= ExecCount + 1'b1;
            else
                SkipCount <= SkipCount + 1'b1;
        end
    end

    // Reset gates the enables directly so NextPC cannot leak through during reset.
    assign PCWrite  = reset & (NextPC | (PCS & CondExLatched));
    assign RegWrite = reset & RegW & CondExLatched;
    assign MemWrite = reset & MemW & CondExLatched;

endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic, built with 4-bit counters so the
// wrap-around is reachable in a few cycles.

module tb_cond_logic;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             CondLatch;
    logic             PCS;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             CntClr;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic             CondExLatched;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SkipCount;

    int vectors;
    int miscompares;

    cond_logic #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .Cond          (Cond),
        .ALUFlags      (ALUFlags),
        .FlagW         (FlagW),
        .CondLatch     (CondLatch),
        .PCS           (PCS),
        .NextPC        (NextPC),
        .RegW          (RegW),
        .MemW          (MemW),
        .CntClr        (CntClr),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .Flags         (Flags),
        .CondExLatched (CondExLatched),
        .ExecCount     (ExecCount),
        .SkipCount     (SkipCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b0;
        Cond      = 4'b0000;
        ALUFlags  = 4'b0000;
        FlagW     = 2'b00;
        CondLatch = 1'b0;
        PCS       = 1'b0;
        NextPC    = 1'b1;
        RegW      = 1'b0;
        MemW      = 1'b0;
        CntClr    = 1'b0;

        // Reset holds everything low, even with NextPC asserted
        #3;
        checkOutput("rst_pcwrite", 16'(PCWrite), 16'h0);
        checkOutput("rst_flags", 16'(Flags), 16'h0);
        checkOutput("rst_latched", 16'(CondExLatched), 16'h0);
        checkOutput("rst_exec", 16'(ExecCount), 16'h0);
        checkOutput("rst_skip", 16'(SkipCount), 16'h0);
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        #1;
        checkOutput("fetch_pcwrite", 16'(PCWrite), 16'h1);
        checkOutput("fetch_regwrite", 16'(RegWrite), 16'h0);
        checkOutput("fetch_memwrite", 16'(MemWrite), 16'h0);

        // EQ with Z=0 fails and suppresses the writes
        NextPC = 1'b0; Cond = 4'b0000; CondLatch = 1'b1;
        applyStimulus();
        CondLatch = 1'b0; RegW = 1'b1; MemW = 1'b1;
        #1;
        checkOutput("eq_latched", 16'(CondExLatched), 16'h0);
        checkOutput("eq_regwrite", 16'(RegWrite), 16'h0);
        checkOutput("eq_memwrite", 16'(MemWrite), 16'h0);
        checkOutput("eq_skip", 16'(SkipCount), 16'h1);
        checkOutput("eq_exec", 16'(ExecCount), 16'h0);

        // AL passes, then writes Z
        RegW = 1'b0; MemW = 1'b0; Cond = 4'b1110; CondLatch = 1'b1;
        applyStimulus();
        CondLatch = 1'b0; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        FlagW = 2'b11; ALUFlags = 4'b0100;
        #1;
        checkOutput("al_regwrite", 16'(RegWrite), 16'h1);
        checkOutput("al_memwrite", 16'(MemWrite), 16'h1);
        checkOutput("al_pcwrite", 16'(PCWrite), 16'h1);
        applyStimulus();
        checkOutput("al_flags", 16'(Flags), 16'h4);
        RegW = 1'b0; MemW = 1'b0; PCS = 1'b0; FlagW = 2'b00;
        Cond = 4'b0000; CondLatch = 1'b1;
        applyStimulus();
        CondLatch = 1'b0;
        checkOutput("eq2_latched", 16'(CondExLatched), 16'h1);
        checkOutput("eq2_exec", 16'(ExecCount), 16'h2);

        // Independent flag halves
        FlagW = 2'b11; ALUFlags = 4'b1111;
        applyStimulus();
        checkOutput("full_flags", 16'(Flags), 16'hF);
        FlagW = 2'b01; ALUFlags = 4'b0000;
        applyStimulus();
        checkOutput("cv_flags", 16'(Flags), 16'hC);
        FlagW = 2'b00; Cond = 4'b0010; CondLatch = 1'b1;
        applyStimulus();
        CondLatch = 1'b0;
        checkOutput("cs_latched", 16'(CondExLatched), 16'h0);
        checkOutput("cs_skip", 16'(SkipCount), 16'h2);
        FlagW = 2'b10; ALUFlags = 4'b0000;
        applyStimulus();
        checkOutput("blocked_flags", 16'(Flags), 16'hC);

        // GT on old flags while a same-cycle flag write is blocked by old latch
        FlagW = 2'b00; Cond = 4'b1110; CondLatch = 1'b1;
        applyStimulus();
        CondLatch = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1001;
        applyStimulus();
        checkOutput("nv_flags", 16'(Flags), 16'h9);
        FlagW = 2'b00; Cond = 4'b0000; CondLatch = 1'b1;
        applyStimulus();
        checkOutput("eq3_latched", 16'(CondExLatched), 16'h0);
        Cond = 4'b1100; FlagW = 2'b11; ALUFlags = 4'b0100;
        applyStimulus();
        CondLatch = 1'b0; FlagW = 2'b00;
        checkOutput("gt_latched", 16'(CondExLatched), 16'h1);
        checkOutput("gt_flags", 16'(Flags), 16'h9);
        checkOutput("gt_exec", 16'(ExecCount), 16'h4);
        checkOutput("gt_skip", 16'(SkipCount), 16'h3);

        // Clear, then 16 passing latches wrap the 4-bit counter
        CntClr = 1'b1;
        applyStimulus();
        CntClr = 1'b0;
        checkOutput("clr_exec", 16'(ExecCount), 16'h0);
        checkOutput("clr_skip", 16'(SkipCount), 16'h0);
        Cond = 4'b1110; CondLatch = 1'b1;
        for (int i = 0; i < 15; i++) applyStimulus();
        checkOutput("exec_15", 16'(ExecCount), 16'hF);
        applyStimulus();
        checkOutput("exec_wrap", 16'(ExecCount), 16'h0);
        Cond = 4'b1111;
        applyStimulus();
        checkOutput("nv_cond_latched", 16'(CondExLatched), 16'h0);
        checkOutput("nv_cond_skip", 16'(SkipCount), 16'h1);
        Cond = 4'b1110; CntClr = 1'b1;
        applyStimulus();
        CntClr = 1'b0; CondLatch = 1'b0;
        checkOutput("clrpri_exec", 16'(ExecCount), 16'h0);
        checkOutput("clrpri_skip", 16'(SkipCount), 16'h0);
        checkOutput("clrpri_latched", 16'(CondExLatched), 16'h1);

        // Asynchronous reset mid-cycle
        RegW = 1'b1; NextPC = 1'b1;
        #1;
        checkOutput("pre_rst_regwrite", 16'(RegWrite), 16'h1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_regwrite", 16'(RegWrite), 16'h0);
        checkOutput("async_flags", 16'(Flags), 16'h0);
        checkOutput("async_latched", 16'(CondExLatched), 16'h0);
        checkOutput("async_pcwrite", 16'(PCWrite), 16'h0);
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        checkOutput("post_rst_regwrite", 16'(RegWrite), 16'h0);
        checkOutput("post_rst_pcwrite", 16'(PCWrite), 16'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution control stage for the multicycle ARM datapath. Sits directly downstream of the combinational condition checker.
- Holds the architectural NZCV flag register and evaluates the instruction condition against it through an instantiated condcheck.
- Latches the pass/fail result in the decode cycle and gates the controller's PC, register-file and memory write enables with it.
- Keeps wrapping performance counters of executed and skipped instructions.

Parameters:
CNT_W, 16, width of ExecCount and SkipCount.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Cond  input  4  instruction condition field, Instr[31:28]
ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle
FlagW  input  2  flag write request; [1] = N,Z, [0] = C,V
CondLatch  input  1  high for exactly the decode cycle of each instruction
PCS  input  1  instruction writes PC (branch or Rd=R15)
NextPC  input  1  unconditional PC update (fetch)
RegW  input  1  controller register-write request
MemW  input  1  controller memory-write request
CntClr  input  1  synchronous clear of both counters
PCWrite  output  1  gated PC write enable
RegWrite  output  1  gated register-file write enable
MemWrite  output  1  gated memory write enable
Flags  output  4  current architectural {N,Z,C,V}
CondExLatched  output  1  latched condition result for the in-flight instruction
ExecCount  output  CNT_W  instructions whose condition passed
SkipCount  output  CNT_W  instructions whose condition failed

Behaviour:
- Reset (asynchronous on reset=0):
  - Flags=4'b0000, CondExLatched=0, ExecCount=0, SkipCount=0.
  - PCWrite, RegWrite and MemWrite are forced to 0 while reset=0, regardless of NextPC.
- CondEx (internal, combinational):
  - Output of the condcheck instance with inputs Cond and the registered Flags.
  - Cond=4'b1111 (undefined) is treated as 0, never X.
- CondExLatched:
  - On a rising clk with CondLatch=1, loads CondEx. Otherwise holds.
  - Latency: one cycle from decode to gated enables.
- Flag register:
  - On a rising clk, Flags[3:2] <= ALUFlags[3:2] when FlagW[1] & CondExLatched.
  - On a rising clk, Flags[1:0] <= ALUFlags[1:0] when FlagW[0] & CondExLatched.
  - Halves update independently. With no write the register holds.
- Gated outputs (combinational from registered state and inputs):
  - PCWrite = NextPC | (PCS & CondExLatched)
  - RegWrite = RegW & CondExLatched
  - MemWrite = MemW & CondExLatched
- Counters:
  - On a rising clk with CondLatch=1: ExecCount += 1 if CondEx=1, otherwise SkipCount += 1.
  - Counters wrap modulo 2^CNT_W with no saturation.
  - CntClr=1 clears both counters and takes priority over an increment in the same cycle.
- Simultaneous events:
  - CondLatch and a flag write in the same cycle: CondEx is evaluated on the pre-update Flags. The flag write is qualified by the old CondExLatched.
  - CondLatch=1 on consecutive cycles is legal. Each cycle latches and counts.
- Reset mid-instruction: all state clears. After reset is released, write enables stay 0 until the next CondLatch, except PCWrite via NextPC.

Test Plan:
- Reset release, then NextPC=1 with everything else 0 -> PCWrite=1, RegWrite=0, MemWrite=0, Flags=0000, counters 0.
- Cond=0000 (EQ) with Flags=0000, CondLatch pulse, then RegW=1 and MemW=1 -> CondExLatched=0, RegWrite=0, MemWrite=0, SkipCount=1, ExecCount=0.
- Cond=1110 (AL), CondLatch, then FlagW=2'b11 with ALUFlags=0100 -> next cycle Flags=0100. Then Cond=0000, CondLatch -> CondExLatched=1, ExecCount=2.
- Partial write: Flags=1111, CondExLatched=1, FlagW=2'b01, ALUFlags=0000 -> Flags=1100. Then FlagW=2'b10 with CondExLatched=0 -> Flags stays 1100.
- Cond=1100 (GT) with Flags=1001 (N=V, Z=0), CondLatch and FlagW=11 with ALUFlags=0100 in the same cycle -> CondExLatched=1 (old flags used), Flags unchanged (old latched value was 0).
- CNT_W=4, 16 consecutive passing CondLatch pulses -> ExecCount wraps 15->0. CntClr asserted together with CondLatch -> both counters 0 after the edge.
- reset pulled low mid-cycle while RegW=1 and CondExLatched=1 -> RegWrite drops to 0 immediately, Flags=0000 without waiting for a clock edge.
